// File: rtl/keylock_ctrl_param.sv
// keylock_ctrl_param: parametrised keypad lock controller.
// Collects digit keystrokes, checks them against a stored code, and toggles
// the lock. It also handles on-device code change, a retry limit with a timed
// lockout, an entry inactivity timeout, and timed status LEDs.
// Every output comes straight from a flop. Each flop loads the value that the
// next-state logic computes for the state being entered.
module keylock_ctrl_param #(
  parameter int                          CODE_LEN     = 4,
  parameter int                          KEY_W        = 4,
  parameter logic [CODE_LEN*KEY_W-1:0]   DEFAULT_CODE = 16'h1234,
  parameter logic [KEY_W-1:0]            KEY_ENTER    = 4'd9,
  parameter logic [KEY_W-1:0]            KEY_CANCEL   = 4'd7,
  parameter logic [KEY_W-1:0]            KEY_SET      = 4'd8,
  parameter int                          MAX_TRIES    = 3,
  parameter int                          BLINK_CYC    = 8,
  parameter int                          LOCKOUT_CYC  = 32,
  parameter int                          IDLE_TO      = 64
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            rdy,
  input  logic [KEY_W-1:0]                keypress,
  output logic                            locked,
  output logic                            toggle_pulse,
  output logic                            led_ok,
  output logic                            led_err,
  output logic                            lockout,
  output logic                            set_mode,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt
);

  localparam int BUF_W   = CODE_LEN * KEY_W;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (BLINK_CYC > LOCKOUT_CYC) ?
                           ((BLINK_CYC > IDLE_TO) ? BLINK_CYC : IDLE_TO) :
                           ((LOCKOUT_CYC > IDLE_TO) ? LOCKOUT_CYC : IDLE_TO);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ENTRY       = 3'd1,
    S_OK          = 3'd2,
    S_ERR         = 3'd3,
    S_LOCKOUT     = 3'd4,
    S_SET_NEW     = 3'd5,
    S_SET_CONFIRM = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUF_W-1:0]   code_q, code_d;
  logic [BUF_W-1:0]   cand_q, cand_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               locked_q, locked_d;
  logic               toggle_q, toggle_d;
  logic               led_ok_q, led_ok_d;
  logic               led_err_q, led_err_d;
  logic               lockout_q, lockout_d;
  logic               set_mode_q, set_mode_d;

  logic [BUF_W-1:0]   buf_shift_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [TRY_W-1:0]   tries_inc_s;
  logic               buf_full_s;

  // A key counts as a digit unless it is one of the three command keys.
  function automatic logic is_digit(input logic [KEY_W-1:0] k);
    is_digit = (k != KEY_ENTER) && (k != KEY_CANCEL) && (k != KEY_SET);
  endfunction

  // Precompute the shifted buffer, saturating counts and the full-buffer flag.
  always_comb begin
    buf_shift_s = (buf_q << KEY_W) | BUF_W'(keypress);
    cnt_inc_s   = (cnt_q == CNT_W'(CODE_LEN)) ? cnt_q : cnt_q + CNT_W'(1);
    tries_inc_s = (tries_q == TRY_W'(MAX_TRIES)) ? tries_q : tries_q + TRY_W'(1);
    buf_full_s  = (cnt_q == CNT_W'(CODE_LEN));
  end

  // Next-state logic: key handling, timers, code/candidate updates and output decode.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    cand_d   = cand_q;
    tries_d  = tries_q;
    timer_d  = timer_q;
    locked_d = locked_q;
    toggle_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rdy && is_digit(keypress)) begin
          state_d = S_ENTRY;
          timer_d = '0;
          buf_d   = buf_shift_s;
          cnt_d   = cnt_inc_s;
        end else if (rdy && (keypress == KEY_SET)) begin
          timer_d = '0;
          if (locked_q) begin
            state_d = S_ERR;
          end else begin
            state_d = S_SET_NEW;
          end
        end else begin
          // ENTER and CANCEL do nothing here.
          state_d = S_IDLE;
        end
      end

      S_ENTRY, S_SET_NEW, S_SET_CONFIRM: begin
        if (!rdy) begin
          // Inactivity timeout. Abandon the entry quietly.
          if (timer_q == TMR_W'(IDLE_TO - 1)) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else begin
          timer_d = '0;
          if (keypress == KEY_CANCEL) begin
            state_d = S_IDLE;
          end else if (is_digit(keypress)) begin
            buf_d = buf_shift_s;
            cnt_d = cnt_inc_s;
          end else if (keypress == KEY_ENTER) begin
            case (state_q)
              S_ENTRY: begin
                if (buf_full_s && (buf_q == code_q)) begin
                  state_d  = S_OK;
                  locked_d = ~locked_q;
                  toggle_d = 1'b1;
                  tries_d  = '0;
                end else if (tries_inc_s == TRY_W'(MAX_TRIES)) begin
                  state_d = S_LOCKOUT;
                  tries_d = tries_inc_s;
                end else begin
                  state_d = S_ERR;
                  tries_d = tries_inc_s;
                end
              end
              S_SET_NEW: begin
                if (buf_full_s) begin
                  cand_d  = buf_q;
                  buf_d   = '0;
                  cnt_d   = '0;
                  state_d = S_SET_CONFIRM;
                end else begin
                  state_d = S_ERR;
                end
              end
              S_SET_CONFIRM: begin
                if (buf_full_s && (buf_q == cand_q)) begin
                  code_d  = cand_q;
                  state_d = S_OK;
                end else begin
                  state_d = S_ERR;
                end
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end else begin
            // SET does nothing while a code is being typed.
            state_d = state_q;
          end
        end
      end

      S_OK, S_ERR: begin
        if (timer_q == TMR_W'(BLINK_CYC - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_LOCKOUT: begin
        if (timer_q == TMR_W'(LOCKOUT_CYC - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
          tries_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // The digit buffer is empty in every state that does not collect digits.
    if ((state_d == S_IDLE) || (state_d == S_OK) ||
        (state_d == S_ERR)  || (state_d == S_LOCKOUT)) begin
      buf_d = '0;
      cnt_d = '0;
    end else begin
      buf_d = buf_d;
    end

    led_ok_d   = (state_d == S_OK);
    led_err_d  = (state_d == S_ERR) || (state_d == S_LOCKOUT);
    lockout_d  = (state_d == S_LOCKOUT);
    set_mode_d = (state_d == S_SET_NEW) || (state_d == S_SET_CONFIRM);
  end

  // State, datapath and output registers. resetN is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      code_q     <= DEFAULT_CODE;
      cand_q     <= '0;
      tries_q    <= '0;
      timer_q    <= '0;
      locked_q   <= 1'b1;
      toggle_q   <= 1'b0;
      led_ok_q   <= 1'b0;
      led_err_q  <= 1'b0;
      lockout_q  <= 1'b0;
      set_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      cand_q     <= cand_d;
      tries_q    <= tries_d;
      timer_q    <= timer_d;
      locked_q   <= locked_d;
      toggle_q   <= toggle_d;
      led_ok_q   <= led_ok_d;
      led_err_q  <= led_err_d;
      lockout_q  <= lockout_d;
      set_mode_q <= set_mode_d;
    end
  end

  assign locked       = locked_q;
  assign toggle_pulse = toggle_q;
  assign led_ok       = led_ok_q;
  assign led_err      = led_err_q;
  assign lockout      = lockout_q;
  assign set_mode     = set_mode_q;
  assign digit_cnt    = cnt_q;

endmodule

// File: tb/tb_keylock_ctrl_param.sv
// Testbench for keylock_ctrl_param. A reference model tracks the typed digits
// in a queue and the remaining display time in a countdown. The bench compares
// every DUT output against that model each cycle, and adds directed checks
// from the test plan.
module tb_keylock_ctrl_param;

  localparam int CL      = 4;
  localparam int BLINK   = 8;
  localparam int LOCKC   = 32;
  localparam int IDLE_TO = 64;
  localparam int MAXT    = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] keypress = 4'd0;
  logic       locked, toggle_pulse, led_ok, led_err, lockout, set_mode;
  logic [2:0] digit_cnt;

  always #5 clk = ~clk;

  keylock_ctrl_param #(
    .CODE_LEN(4), .KEY_W(4), .DEFAULT_CODE(16'h1234), .KEY_ENTER(4'd9),
    .KEY_CANCEL(4'd7), .KEY_SET(4'd8), .MAX_TRIES(3), .BLINK_CYC(8),
    .LOCKOUT_CYC(32), .IDLE_TO(64)
  ) dut (
    .clk(clk), .resetN(resetN), .rdy(rdy), .keypress(keypress),
    .locked(locked), .toggle_pulse(toggle_pulse), .led_ok(led_ok),
    .led_err(led_err), .lockout(lockout), .set_mode(set_mode),
    .digit_cnt(digit_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_OK = 2, M_ERR = 3, M_LOCK = 4,
                 M_SNEW = 5, M_SCONF = 6;
  int m_mode;
  int m_buf[$];
  int m_code[$];
  int m_cand[$];
  int m_tries, m_remain, m_idle;
  bit m_locked, m_toggle;

  function automatic void model_reset();
    m_mode = M_IDLE; m_buf.delete(); m_cand.delete();
    m_code = '{1, 2, 3, 4};
    m_tries = 0; m_remain = 0; m_idle = 0; m_locked = 1'b1; m_toggle = 1'b0;
  endfunction

  function automatic bit same(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void go(input int mode, input int len);
    m_mode = mode; m_remain = len; m_buf.delete();
  endfunction

  function automatic void model_step(input bit rn, input bit r, input int k);
    bit dig;
    dig = (k != 9) && (k != 7) && (k != 8);
    if (!rn) begin model_reset(); return; end
    m_toggle = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (r && dig) begin
          m_buf.delete(); m_buf.push_back(k); m_mode = M_ENTRY; m_idle = 0;
        end else if (r && k == 8) begin
          if (!m_locked) begin m_mode = M_SNEW; m_idle = 0; m_buf.delete(); end
          else go(M_ERR, BLINK);
        end
      end
      M_OK, M_ERR, M_LOCK: begin
        m_remain--;
        if (m_remain == 0) begin
          if (m_mode == M_LOCK) m_tries = 0;
          m_mode = M_IDLE;
        end
      end
      default: begin
        if (!r) begin
          m_idle++;
          if (m_idle == IDLE_TO) begin m_mode = M_IDLE; m_buf.delete(); end
        end else begin
          m_idle = 0;
          if (k == 7) begin
            m_mode = M_IDLE; m_buf.delete();
          end else if (dig) begin
            m_buf.push_back(k);
            if (m_buf.size() > CL) void'(m_buf.pop_front());
          end else if (k == 9) begin
            if (m_mode == M_ENTRY) begin
              if (same(m_buf, m_code)) begin
                m_locked = !m_locked; m_toggle = 1'b1; m_tries = 0; go(M_OK, BLINK);
              end else begin
                m_tries++;
                if (m_tries == MAXT) go(M_LOCK, LOCKC); else go(M_ERR, BLINK);
              end
            end else if (m_mode == M_SNEW) begin
              if (m_buf.size() == CL) begin
                m_cand = m_buf; m_buf.delete(); m_mode = M_SCONF;
              end else go(M_ERR, BLINK);
            end else begin
              if (same(m_buf, m_cand)) begin m_code = m_cand; go(M_OK, BLINK); end
              else go(M_ERR, BLINK);
            end
          end
        end
      end
    endcase
  endfunction

  function automatic logic [8:0] mdl_vec();
    return {m_locked, m_toggle, m_mode == M_OK, (m_mode == M_ERR) || (m_mode == M_LOCK),
            m_mode == M_LOCK, (m_mode == M_SNEW) || (m_mode == M_SCONF), 3'(m_buf.size())};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {locked, toggle_pulse, led_ok, led_err, lockout, set_mode, digit_cnt};
  endfunction

  // Drive one cycle: k >= 0 is a key, -1 an idle cycle; rn = 0 asserts reset.
  task automatic drive_cycle(input bit rn, input bit r, input int k);
    resetN = rn; rdy = r; keypress = 4'(k);
    @(posedge clk);
    model_step(rn, r, k);
    #1;
  endtask

  function automatic void add_gap(ref int q[$], input int n);
    repeat (n) q.push_back(-1);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_cycle(1'b0, 1'b0, 0);
    drive_cycle(1'b0, 1'b1, 1);
    n_vec++;
    if (dut_vec() !== 9'b1_0_0_0_0_0_000) begin
      n_err++; $display("FAIL reset_values: got %b expected %b", dut_vec(), 9'b100000000);
    end
    drive_cycle(1'b1, 1'b0, 0);
  endtask

  task automatic test_unlock();
    int seq[$];
    int ok_cyc, tog_cyc;
    seq = '{1, 2, 3, 4, 9}; add_gap(seq, 12);
    ok_cyc = 0; tog_cyc = 0;
    foreach (seq[i]) begin
      drive_cycle(1'b1, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
      ok_cyc += int'(led_ok); tog_cyc += int'(toggle_pulse);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL unlock step%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (ok_cyc !== BLINK || tog_cyc !== 1 || locked !== 1'b0 || digit_cnt !== 3'd0) begin
      n_err++; $display("FAIL unlock_summary: ok=%0d tog=%0d locked=%b cnt=%0d expected 8 1 0 0",
                        ok_cyc, tog_cyc, locked, digit_cnt);
    end
  endtask

  task automatic test_overflow_short();
    int seq[$];
    int err_cyc;
    seq = '{5, 1, 2, 3, 4, 9}; add_gap(seq, 10);
    seq.push_back(1); seq.push_back(2); seq.push_back(3); seq.push_back(9); add_gap(seq, 10);
    err_cyc = 0;
    foreach (seq[i]) begin
      drive_cycle(1'b1, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
      err_cyc += int'(led_err);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL overflow_short step%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (locked !== 1'b1 || err_cyc !== BLINK || m_tries !== 1) begin
      n_err++; $display("FAIL overflow_short_summary: locked=%b err=%0d expected 1 8 (tries 1)", locked, err_cyc);
    end
  endtask

  task automatic test_lockout();
    int seq[$];
    int lo_cyc;
    drive_cycle(1'b0, 1'b0, 0);
    repeat (2) begin seq.push_back(1); seq.push_back(1); seq.push_back(1); seq.push_back(1);
                     seq.push_back(9); add_gap(seq, 9); end
    seq.push_back(1); seq.push_back(1); seq.push_back(1); seq.push_back(1); seq.push_back(9);
    seq.push_back(1); seq.push_back(2); seq.push_back(3); seq.push_back(4); seq.push_back(9);
    add_gap(seq, 30);
    seq.push_back(1); seq.push_back(2); seq.push_back(3); seq.push_back(4); seq.push_back(9);
    add_gap(seq, 10);
    lo_cyc = 0;
    foreach (seq[i]) begin
      drive_cycle(1'b1, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
      lo_cyc += int'(lockout);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL lockout step%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (lo_cyc !== LOCKC || locked !== 1'b0) begin
      n_err++; $display("FAIL lockout_summary: lockout_cycles=%0d locked=%b expected 32 0", lo_cyc, locked);
    end
  endtask

  task automatic test_code_change();
    int seq[$];
    seq = '{8, 5, 6, 5, 6, 9, 5, 6, 5, 6, 9}; add_gap(seq, 10);
    seq.push_back(5); seq.push_back(6); seq.push_back(5); seq.push_back(6); seq.push_back(9); add_gap(seq, 10);
    seq.push_back(1); seq.push_back(2); seq.push_back(3); seq.push_back(4); seq.push_back(9); add_gap(seq, 10);
    foreach (seq[i]) begin
      drive_cycle(1'b1, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL code_change step%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL code_change_locked: got %b expected 1", locked);
    end
    // Unlock with the new code, then attempt a mismatched code change.
    seq = '{5, 6, 5, 6, 9}; add_gap(seq, 10);
    seq.push_back(8); seq.push_back(1); seq.push_back(1); seq.push_back(1); seq.push_back(1);
    seq.push_back(9); seq.push_back(5); seq.push_back(6); seq.push_back(5); seq.push_back(0);
    seq.push_back(9); add_gap(seq, 10);
    seq.push_back(5); seq.push_back(6); seq.push_back(5); seq.push_back(6); seq.push_back(9); add_gap(seq, 10);
    foreach (seq[i]) begin
      drive_cycle(1'b1, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL code_mismatch step%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL old_code_kept: locked=%b expected 1", locked);
    end
  endtask

  task automatic test_set_locked_timeout();
    int seq[$];
    int err_cyc;
    seq = '{8}; add_gap(seq, 10);
    foreach (seq[i]) begin
      drive_cycle(1'b1, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL set_locked step%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    drive_cycle(1'b1, 1'b1, 1);
    drive_cycle(1'b1, 1'b1, 2);
    err_cyc = 0;
    for (int k = 1; k <= IDLE_TO + 2; k++) begin
      drive_cycle(1'b1, 1'b0, 0);
      err_cyc += int'(led_err);
      n_vec++;
      if (digit_cnt !== ((k < IDLE_TO) ? 3'd2 : 3'd0) || dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL timeout idle%0d: cnt=%0d vec=%b expected vec %b", k, digit_cnt, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (err_cyc !== 0) begin
      n_err++; $display("FAIL timeout_no_err: led_err cycles=%0d expected 0", err_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int seq[$];
    drive_cycle(1'b0, 1'b0, 0);
    repeat (3) begin seq.push_back(1); seq.push_back(1); seq.push_back(1); seq.push_back(1);
                     seq.push_back(9); add_gap(seq, 9); end
    foreach (seq[i]) drive_cycle(1'b1, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
    n_vec++;
    if (lockout !== 1'b1) begin
      n_err++; $display("FAIL in_lockout: got %b expected 1", lockout);
    end
    drive_cycle(1'b0, 1'b1, 1);
    n_vec++;
    if (dut_vec() !== 9'b100000000) begin
      n_err++; $display("FAIL reset_in_lockout: got %b expected %b", dut_vec(), 9'b100000000);
    end
    seq = '{1, 2, 3, 4, 9}; add_gap(seq, 10);
    seq.push_back(8); seq.push_back(5); seq.push_back(6); seq.push_back(5); seq.push_back(6); seq.push_back(9);
    seq.push_back(5); seq.push_back(6); seq.push_back(5); seq.push_back(6); seq.push_back(9);
    seq.push_back(5); seq.push_back(-2); seq.push_back(1); seq.push_back(2); seq.push_back(3);
    seq.push_back(4); seq.push_back(9); add_gap(seq, 3);
    foreach (seq[i]) begin
      drive_cycle(seq[i] != -2, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL reset_mid step%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL default_code_restored: locked=%b expected 0", locked);
    end
  endtask

  task automatic test_random();
    int seq[$];
    int act, d[$];
    for (int it = 0; it < 300; it++) begin
      seq.delete();
      act = $urandom_range(0, 9);
      case (act)
        0, 1: begin
          foreach (m_code[j]) seq.push_back(m_code[j]);
          seq.push_back(9);
        end
        2, 3: begin
          repeat ($urandom_range(1, 6)) seq.push_back($urandom_range(0, 6));
          seq.push_back(9);
        end
        4: begin
          d.delete();
          repeat (4) d.push_back($urandom_range(1, 6));
          seq.push_back(8);
          foreach (d[j]) seq.push_back(d[j]);
          seq.push_back(9);
          if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 3)] = 0;
          foreach (d[j]) seq.push_back(d[j]);
          seq.push_back(9);
        end
        5: seq.push_back($urandom_range(0, 1) ? 7 : 8);
        6: add_gap(seq, $urandom_range(1, 70));
        7: repeat (6) seq.push_back($urandom_range(0, 1) ? int'($urandom_range(0, 15)) : -1);
        8: if ($urandom_range(0, 3) == 0) seq.push_back(-2); else add_gap(seq, 2);
        default: add_gap(seq, $urandom_range(1, 12));
      endcase
      foreach (seq[i]) begin
        drive_cycle(seq[i] != -2, seq[i] >= 0, seq[i] >= 0 ? seq[i] : 0);
        n_vec++;
        if (dut_vec() !== mdl_vec()) begin
          n_err++; $display("FAIL random it%0d step%0d: got %b expected %b", it, i, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_unlock();
    test_overflow_short();
    test_lockout();
    test_code_change();
    test_set_locked_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
